// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch PC generator.
package fetch_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      DS_WAIT = 1'b1
   } fetch_state_t;

   localparam logic [31:0] FETCH_RESET_PC = 32'hBFC0_0000;
   localparam logic [1:0]  MASK_PAIR      = 2'b11;
   localparam logic [1:0]  MASK_SLOT0     = 2'b01;

endpackage

// File: rtl/fetch_pc_gen.sv
// Dual-issue fetch PC generator: picks the next fetch pair address from redirects,
// branch predictions and the sequential path, honouring MIPS delay slots.
module fetch_pc_gen
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = FETCH_RESET_PC,
   parameter bit          ENABLE_PRED = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc_query,
   input  logic [1:0]  br_flag,
   input  logic [31:0] pred0_target,
   input  logic [31:0] pred1_target,
   input  logic        exc_redirect,
   input  logic [31:0] exc_pc,
   input  logic        ex_redirect,
   input  logic [31:0] ex_pc,
   input  logic        if_ready,
   output logic        fetch_valid,
   output logic [31:0] fetch_pc,
   output logic [1:0]  fetch_mask,
   output logic [1:0]  fetch_pred_taken,
   output logic [31:0] fetch_pred_target
);

   logic [31:0]  pc_reg, pc_next;
   logic [31:0]  pend_reg, pend_next;
   fetch_state_t state_reg, state_next;
   logic         flag0, flag1, handshake;

   assign flag0       = br_flag[0] & ENABLE_PRED;
   assign flag1       = br_flag[1] & ENABLE_PRED;
   assign pc_query    = pc_reg;
   assign fetch_pc    = pc_reg;
   assign fetch_valid = !rst && !exc_redirect && !ex_redirect;
   assign handshake   = fetch_valid && if_ready;

   always_comb begin
      fetch_mask        = MASK_PAIR;
      fetch_pred_taken  = 2'b00;
      fetch_pred_target = '0;
      pc_next           = pc_reg;
      state_next        = state_reg;
      pend_next         = pend_reg;

      // DS_WAIT fetches only the owed delay slot; predictions are ignored there.
      if (state_reg == DS_WAIT) begin
         fetch_mask = MASK_SLOT0;
      end else if (flag0) begin
         fetch_pred_taken  = 2'b01;
         fetch_pred_target = pred0_target;
      end else if (flag1) begin
         fetch_pred_taken  = 2'b10;
         fetch_pred_target = pred1_target;
      end

      if (exc_redirect) begin
         pc_next    = exc_pc;
         state_next = RUN;
         pend_next  = '0;
      end else if (ex_redirect) begin
         pc_next    = ex_pc;
         state_next = RUN;
         pend_next  = '0;
      end else if (handshake) begin
         if (state_reg == DS_WAIT) begin
            pc_next    = pend_reg;
            state_next = RUN;
         end else if (flag0) begin
            pc_next = pred0_target;
         end else begin
            pc_next = pc_reg + 32'd8;
            // Slot1 branch: its delay slot sits in the next pair, so defer the target.
            if (flag1) begin
               pend_next  = pred1_target;
               state_next = DS_WAIT;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg    <= RESET_PC;
         state_reg <= RUN;
         pend_reg  <= '0;
      end else begin
         pc_reg    <= pc_next;
         state_reg <= state_next;
         pend_reg  <= pend_next;
      end
   end

endmodule
